lock_access_controller: RTL and testbench

- Sequences the keypad password-entry datapath into door-lock decisions.
- Consumes the 4-digit packed BCD word and its one-cycle ready pulse from the keypad entry block, and compares the word against a stored password.
- Drives the door unlock, enforces a failed-attempt lockout with alarm, and supports a password change while the door is unlocked.
- Sits between the keypad entry block and the door actuator / alarm outputs of the smart-home top level.

---
 rtl/lock_access_controller.sv | 137 +++++++++++++
 tb/tb_lock_access_controller.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_access_controller.sv
// Door-lock sequencer: compares keypad entries against a stored password,
// times unlock/lockout windows, and accepts a new password while unlocked.
module lock_access_controller #(
    parameter int          PW_W           = 16,
    parameter logic [15:0] DEFAULT_PW     = 16'h1234,
    parameter int          MAX_FAIL       = 3,
    parameter int          UNLOCK_CYCLES  = 500,
    parameter int          LOCKOUT_CYCLES = 1000,
    parameter int          TMR_W          = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PW_W-1:0] entered_password,
    input  logic            password_ready,
    input  logic            change_req,
    input  logic            lock_cmd,
    output logic            door_unlock,
    output logic            alarm,
    output logic [2:0]      fail_count,
    output logic            change_done,
    output logic [1:0]      state_out
);

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        CHG_WAIT = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    localparam logic [TMR_W-1:0] UNLOCK_RELOAD  = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_RELOAD = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]       FAIL_LIMIT     = 3'(MAX_FAIL);

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [PW_W-1:0]   stored_pw_q, stored_pw_d;
    logic [2:0]        fail_q, fail_d;
    logic              change_done_q, change_done_d;

    logic              timer_zero;
    logic [TMR_W-1:0]  timer_dec;

    assign timer_zero = (timer_q == '0);
    assign timer_dec  = timer_q - TMR_W'(1);

    // NOTE: every next-state signal gets a default before the case so the
    // combinational block never holds a value and cannot infer a latch.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        stored_pw_d   = stored_pw_q;
        fail_d        = fail_q;
        change_done_d = 1'b0;

        case (state_q)
            LOCKED: begin
                if (password_ready) begin
                    if (entered_password == stored_pw_q) begin
                        state_d = UNLOCKED;
                        timer_d = UNLOCK_RELOAD;
                        fail_d  = '0;
                    end else if (fail_q + 3'd1 == FAIL_LIMIT) begin
                        state_d = LOCKOUT;
                        timer_d = LOCKOUT_RELOAD;
                        fail_d  = FAIL_LIMIT;
                    end else begin
                        fail_d = fail_q + 3'd1;
                    end
                end
            end

            UNLOCKED: begin
                timer_d = timer_dec;
                if (lock_cmd || timer_zero) begin
                    state_d = LOCKED;
                    timer_d = '0;
                end else if (change_req) begin
                    state_d = CHG_WAIT;
                    timer_d = UNLOCK_RELOAD;
                end
            end

            CHG_WAIT: begin
                timer_d = timer_dec;
                if (lock_cmd) begin
                    state_d = LOCKED;
                    timer_d = '0;
                end else if (password_ready) begin
                    stored_pw_d   = entered_password;
                    change_done_d = 1'b1;
                    state_d       = UNLOCKED;
                    timer_d       = UNLOCK_RELOAD;
                end else if (timer_zero) begin
                    state_d = LOCKED;
                    timer_d = '0;
                end
            end

            LOCKOUT: begin
                timer_d = timer_dec;
                if (timer_zero) begin
                    state_d = LOCKED;
                    timer_d = '0;
                    fail_d  = '0;
                end
            end

            default: state_d = LOCKED;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so all flops
    // update together from the values computed before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= LOCKED;
            timer_q       <= '0;
            stored_pw_q   <= DEFAULT_PW[PW_W-1:0];
            fail_q        <= '0;
            change_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            stored_pw_q   <= stored_pw_d;
            fail_q        <= fail_d;
            change_done_q <= change_done_d;
        end
    end

    assign door_unlock = (state_q == UNLOCKED) || (state_q == CHG_WAIT);
    assign alarm       = (state_q == LOCKOUT);
    assign fail_count  = fail_q;
    assign change_done = change_done_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_lock_access_controller.sv
// Bench for lock_access_controller: directed scenarios plus random traffic
// checked against a deadline-based behavioural model.
module tb_lock_access_controller;

    localparam int          PW_W           = 16;
    localparam logic [15:0] DEFAULT_PW     = 16'h1234;
    localparam int          MAX_FAIL       = 3;
    localparam int          UNLOCK_CYCLES  = 500;
    localparam int          LOCKOUT_CYCLES = 1000;
    localparam int          TMR_W          = 16;

    localparam int M_LOCKED = 0, M_UNLOCKED = 1, M_CHG = 2, M_LOCKOUT = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [PW_W-1:0] entered_password = '0;
    logic            password_ready = 1'b0;
    logic            change_req = 1'b0;
    logic            lock_cmd = 1'b0;
    logic            door_unlock;
    logic            alarm;
    logic [2:0]      fail_count;
    logic            change_done;
    logic [1:0]      state_out;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode plus the absolute edge number at which the
    // current timed window ends.
    int          m_mode;
    logic [15:0] m_pw;
    int          m_fail;
    int          m_deadline;
    bit          m_done;
    int          edge_no = 0;

    always #5 clk = ~clk;

    lock_access_controller #(
        .PW_W(PW_W), .DEFAULT_PW(DEFAULT_PW), .MAX_FAIL(MAX_FAIL),
        .UNLOCK_CYCLES(UNLOCK_CYCLES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
        .TMR_W(TMR_W)
    ) dut (
        .clk(clk), .reset(reset),
        .entered_password(entered_password), .password_ready(password_ready),
        .change_req(change_req), .lock_cmd(lock_cmd),
        .door_unlock(door_unlock), .alarm(alarm), .fail_count(fail_count),
        .change_done(change_done), .state_out(state_out)
    );

    task automatic model_reset();
        m_mode = M_LOCKED;
        m_pw   = DEFAULT_PW;
        m_fail = 0;
        m_done = 0;
    endtask

    task automatic model_edge(input bit rdy, input logic [15:0] pw,
                              input bit chg, input bit lk);
        m_done = 0;
        case (m_mode)
            M_LOCKED: if (rdy) begin
                if (pw == m_pw) begin
                    m_mode = M_UNLOCKED; m_fail = 0;
                    m_deadline = edge_no + UNLOCK_CYCLES;
                end else begin
                    m_fail++;
                    if (m_fail == MAX_FAIL) begin
                        m_mode = M_LOCKOUT;
                        m_deadline = edge_no + LOCKOUT_CYCLES;
                    end
                end
            end
            M_UNLOCKED: begin
                if (lk || edge_no == m_deadline) m_mode = M_LOCKED;
                else if (chg) begin
                    m_mode = M_CHG; m_deadline = edge_no + UNLOCK_CYCLES;
                end
            end
            M_CHG: begin
                if (lk) m_mode = M_LOCKED;
                else if (rdy) begin
                    m_pw = pw; m_done = 1; m_mode = M_UNLOCKED;
                    m_deadline = edge_no + UNLOCK_CYCLES;
                end else if (edge_no == m_deadline) m_mode = M_LOCKED;
            end
            default: if (edge_no == m_deadline) begin
                m_mode = M_LOCKED; m_fail = 0;
            end
        endcase
    endtask

    // Called at a falling edge; drives one cycle of inputs and returns at
    // the next falling edge with the model advanced to match.
    task automatic step(input bit rdy, input logic [15:0] pw,
                        input bit chg, input bit lk);
        password_ready = rdy; entered_password = pw;
        change_req = chg; lock_cmd = lk;
        @(posedge clk);
        edge_no++;
        model_edge(rdy, pw, chg, lk);
        @(negedge clk);
        password_ready = 0; entered_password = '0;
        change_req = 0; lock_cmd = 0;
    endtask

    task automatic idle();
        step(0, 16'h0, 0, 0);
    endtask

    task automatic apply_reset();
        reset = 1;
        password_ready = 0; change_req = 0; lock_cmd = 0; entered_password = '0;
        repeat (2) @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({state_out, door_unlock, alarm, fail_count, change_done} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got state=%0d door=%b alarm=%b fail=%0d done=%b, want all 0",
                     state_out, door_unlock, alarm, fail_count, change_done);
        end
    endtask

    task automatic test_unlock_timeout();
        int n;
        step(1, 16'h1234, 0, 0);
        checks++;
        if (door_unlock !== 1'b1 || state_out !== 2'd1 || fail_count !== 3'd0) begin
            errors++;
            $display("FAIL unlock_latency: door=%b state=%0d fail=%0d, want 1/1/0",
                     door_unlock, state_out, fail_count);
        end
        n = 1;
        for (int i = 0; i < 600 && door_unlock; i++) begin
            idle();
            if (door_unlock) n++;
        end
        checks++;
        if (n != UNLOCK_CYCLES || state_out !== 2'd0) begin
            errors++;
            $display("FAIL unlock_window: unlocked %0d cycles then state=%0d, want %0d then 0",
                     n, state_out, UNLOCK_CYCLES);
        end
    endtask

    task automatic test_lockout();
        int n;
        logic [15:0] wrong [3];
        wrong[0] = 16'h1111; wrong[1] = 16'h2222; wrong[2] = 16'h3333;
        for (int i = 0; i < 2; i++) begin
            step(1, wrong[i], 0, 0);
            checks++;
            if (fail_count !== 3'(i + 1) || state_out !== 2'd0) begin
                errors++;
                $display("FAIL fail_count_%0d: fail=%0d state=%0d, want %0d/0",
                         i, fail_count, state_out, i + 1);
            end
        end
        step(1, wrong[2], 0, 0);
        checks++;
        if (alarm !== 1'b1 || state_out !== 2'd3 || fail_count !== 3'(MAX_FAIL)) begin
            errors++;
            $display("FAIL lockout_entry: alarm=%b state=%0d fail=%0d, want 1/3/%0d",
                     alarm, state_out, fail_count, MAX_FAIL);
        end
        n = 1;
        step(1, 16'h1234, 0, 0);
        if (alarm) n++;
        checks++;
        if (alarm !== 1'b1 || door_unlock !== 1'b0 || state_out !== 2'd3) begin
            errors++;
            $display("FAIL lockout_ignores_pw: alarm=%b door=%b state=%0d, want 1/0/3",
                     alarm, door_unlock, state_out);
        end
        for (int i = 0; i < 1100 && alarm; i++) begin
            idle();
            if (alarm) n++;
        end
        checks++;
        if (n != LOCKOUT_CYCLES || state_out !== 2'd0 || fail_count !== 3'd0) begin
            errors++;
            $display("FAIL lockout_window: alarm %0d cycles, state=%0d fail=%0d, want %0d/0/0",
                     n, state_out, fail_count, LOCKOUT_CYCLES);
        end
    endtask

    task automatic test_fail_then_correct();
        step(1, 16'h4444, 0, 0);
        step(1, 16'h5555, 0, 0);
        step(1, 16'h1234, 0, 0);
        checks++;
        if (state_out !== 2'd1 || fail_count !== 3'd0 || door_unlock !== 1'b1) begin
            errors++;
            $display("FAIL fail_then_correct: state=%0d fail=%0d door=%b, want 1/0/1",
                     state_out, fail_count, door_unlock);
        end
        step(0, 16'h0, 0, 1);
        checks++;
        if (state_out !== 2'd0) begin
            errors++;
            $display("FAIL lock_cmd: state=%0d, want 0", state_out);
        end
    endtask

    task automatic test_change();
        step(1, 16'h1234, 0, 0);
        step(0, 16'h0, 1, 0);
        checks++;
        if (state_out !== 2'd2 || door_unlock !== 1'b1) begin
            errors++;
            $display("FAIL enter_chg_wait: state=%0d door=%b, want 2/1", state_out, door_unlock);
        end
        step(1, 16'h9876, 0, 0);
        checks++;
        if (change_done !== 1'b1 || state_out !== 2'd1) begin
            errors++;
            $display("FAIL change_store: done=%b state=%0d, want 1/1", change_done, state_out);
        end
        idle();
        checks++;
        if (change_done !== 1'b0) begin
            errors++;
            $display("FAIL change_done_pulse: done=%b, want 0", change_done);
        end
        step(0, 16'h0, 0, 1);
        step(1, 16'h1234, 0, 0);
        checks++;
        if (state_out !== 2'd0 || fail_count !== 3'd1) begin
            errors++;
            $display("FAIL old_pw_rejected: state=%0d fail=%0d, want 0/1", state_out, fail_count);
        end
        step(1, 16'h9876, 0, 0);
        checks++;
        if (state_out !== 2'd1 || fail_count !== 3'd0) begin
            errors++;
            $display("FAIL new_pw_accepted: state=%0d fail=%0d, want 1/0", state_out, fail_count);
        end
        step(0, 16'h0, 0, 1);
    endtask

    task automatic test_chg_collision_and_timeout();
        int n;
        bit saw_done;
        apply_reset();
        step(1, 16'h1234, 0, 0);
        step(0, 16'h0, 1, 0);
        step(1, 16'h5555, 0, 1);
        checks++;
        if (state_out !== 2'd0 || change_done !== 1'b0) begin
            errors++;
            $display("FAIL chg_lock_priority: state=%0d done=%b, want 0/0", state_out, change_done);
        end
        step(1, 16'h1234, 0, 0);
        checks++;
        if (state_out !== 2'd1) begin
            errors++;
            $display("FAIL pw_unchanged_after_lock: state=%0d, want 1", state_out);
        end
        step(0, 16'h0, 1, 0);
        n = (state_out == 2'd2) ? 1 : 0;
        saw_done = 0;
        for (int i = 0; i < 600 && state_out == 2'd2; i++) begin
            idle();
            if (state_out == 2'd2) n++;
            if (change_done) saw_done = 1;
        end
        checks++;
        if (n != UNLOCK_CYCLES || state_out !== 2'd0 || saw_done) begin
            errors++;
            $display("FAIL chg_timeout: chg_wait %0d cycles state=%0d done_seen=%0d, want %0d/0/0",
                     n, state_out, saw_done, UNLOCK_CYCLES);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1, 16'h0bad, 0, 0);
        repeat (5) idle();
        reset = 1;
        #1;
        checks++;
        if (state_out !== 2'd0 || alarm !== 1'b0 || fail_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_in_lockout: state=%0d alarm=%b fail=%0d, want 0/0/0",
                     state_out, alarm, fail_count);
        end
        @(negedge clk);
        reset = 0;
        model_reset();
        step(1, 16'h1234, 0, 0);
        step(0, 16'h0, 1, 0);
        step(1, 16'h4321, 0, 0);
        reset = 1;
        #1;
        checks++;
        if (state_out !== 2'd0 || door_unlock !== 1'b0 || change_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_after_change: state=%0d door=%b done=%b, want 0/0/0",
                     state_out, door_unlock, change_done);
        end
        @(negedge clk);
        reset = 0;
        model_reset();
        step(1, 16'h1234, 0, 0);
        checks++;
        if (state_out !== 2'd1) begin
            errors++;
            $display("FAIL default_pw_restored: state=%0d, want 1", state_out);
        end
        step(0, 16'h0, 0, 1);
    endtask

    task automatic test_random();
        bit rdy, chg, lk;
        logic [15:0] pw;
        logic [7:0] exp_v, got_v;
        for (int i = 0; i < 4000; i++) begin
            rdy = ($urandom_range(0, 7) == 0);
            pw  = ($urandom_range(0, 1) == 1) ? m_pw : 16'($urandom);
            chg = ($urandom_range(0, 31) == 0);
            lk  = ($urandom_range(0, 199) == 0);
            step(rdy, pw, chg, lk);
            exp_v = {2'(m_mode), (m_mode == M_UNLOCKED || m_mode == M_CHG),
                     (m_mode == M_LOCKOUT), 3'(m_fail), m_done};
            got_v = {state_out, door_unlock, alarm, fail_count, change_done};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_cycle_%0d: got {state,door,alarm,fail,done}=%h, want %h",
                         i, got_v, exp_v);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_unlock_timeout();
        test_lockout();
        test_fail_then_correct();
        test_change();
        test_chg_collision_and_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
